// File: rtl/mem_access.sv
// Load/store unit: one data-memory transaction per core request over a
// req/gnt/rvalid bus, with byte-lane alignment and load sign/zero extension.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned H/W accesses).
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        op_legal;
    logic        misalign;
    logic        timeout_hit;
    logic [3:0]  be;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Stores only support B/H/W; loads additionally BU/HU.
    assign op_legal = mem_wr ? (mem_op inside {3'b000, 3'b001, 3'b010})
                             : (mem_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((mem_op[1:0] == 2'b01) && addr[0]) ||
                      ((mem_op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Byte enables, replicated store data and load extraction from the latched request.
    always_comb begin
        be      = 4'b1111;
        st_data = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                be      = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        case (addr_q[1:0])
            2'b00:   ld_byte = dm_rdata[7:0];
            2'b01:   ld_byte = dm_rdata[15:8];
            2'b10:   ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (op_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    // Next-state and next-value logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (lsu_valid) begin
                    rdata_d = '0;
                    if ((mem_rd ^ mem_wr) && op_legal && !misalign) begin
                        addr_d  = addr;
                        wdata_d = wdata;
                        op_d    = mem_op;
                        we_d    = mem_wr;
                        err_d   = 1'b0;
                        state_d = REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (dm_gnt) begin
                    state_d = we_q ? RESP : WAIT;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (dm_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign dm_req    = (state_q == REQ);
    assign dm_we     = dm_req & we_q;
    assign dm_addr   = dm_req ? {addr_q[31:2], 2'b00} : '0;
    assign dm_be     = dm_req ? be : '0;
    assign dm_wdata  = dm_we ? st_data : '0;
    assign lsu_done  = (state_q == RESP);
    assign lsu_err   = lsu_done & err_q;
    assign lsu_rdata = lsu_done ? rdata_q : '0;
    assign lsu_stall = lsu_valid & ~lsu_done;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        lsu_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    int n_checks;
    int n_errors;
    int req_cnt;

    mem_access #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .lsu_stall (lsu_stall),
        .lsu_done  (lsu_done),
        .lsu_err   (lsu_err),
        .lsu_rdata (lsu_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_be     (dm_be),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        lsu_valid = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_op    = 3'b000;
        addr      = '0;
        wdata     = '0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
    endtask

    // Store with immediate grant: REQ one cycle after accept, done the cycle after.
    task automatic run_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        lsu_valid = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0;
        mem_op = op; addr = a; wdata = wd; dm_gnt = 1'b1;
        #1;
        chk({tag, "_stall_accept"}, 32'(lsu_stall), 32'd1);
        tick;
        chk({tag, "_req"},   32'(dm_req),  32'd1);
        chk({tag, "_we"},    32'(dm_we),   32'd1);
        chk({tag, "_addr"},  dm_addr,      exp_addr);
        chk({tag, "_be"},    32'(dm_be),   32'(exp_be));
        chk({tag, "_wdata"}, dm_wdata,     exp_wd);
        chk({tag, "_done_early"}, 32'(lsu_done), 32'd0);
        tick;
        chk({tag, "_done"},  32'(lsu_done), 32'd1);
        chk({tag, "_err"},   32'(lsu_err),  32'd0);
        chk({tag, "_rdata"}, lsu_rdata,     32'd0);
        chk({tag, "_stall_done"}, 32'(lsu_stall), 32'd0);
        idle_inputs;
        tick;
        chk({tag, "_done_pulse"}, 32'(lsu_done), 32'd0);
    endtask

    // Load with immediate grant and rvalid in the following cycle.
    task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] word, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_rd);
        lsu_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        mem_op = op; addr = a; wdata = 32'hFFFF_FFFF; dm_gnt = 1'b1;
        tick;
        chk({tag, "_req"},   32'(dm_req),  32'd1);
        chk({tag, "_we"},    32'(dm_we),   32'd0);
        chk({tag, "_addr"},  dm_addr,      exp_addr);
        chk({tag, "_be"},    32'(dm_be),   32'(exp_be));
        chk({tag, "_wdata"}, dm_wdata,     32'd0);
        tick;
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = word;
        chk({tag, "_wait_done"}, 32'(lsu_done), 32'd0);
        tick;
        chk({tag, "_done"},  32'(lsu_done), 32'd1);
        chk({tag, "_err"},   32'(lsu_err),  32'd0);
        chk({tag, "_rdata"}, lsu_rdata,     exp_rd);
        idle_inputs;
        tick;
        chk({tag, "_done_pulse"}, 32'(lsu_done), 32'd0);
    endtask

    // Request rejected before the bus: error response next cycle, no dm_req.
    task automatic run_err(input string tag, input logic rd, input logic wr,
                           input logic [2:0] op, input logic [31:0] a);
        lsu_valid = 1'b1; mem_rd = rd; mem_wr = wr;
        mem_op = op; addr = a; wdata = 32'h1234_5678; dm_gnt = 1'b1;
        tick;
        chk({tag, "_req"},   32'(dm_req),   32'd0);
        chk({tag, "_done"},  32'(lsu_done), 32'd1);
        chk({tag, "_err"},   32'(lsu_err),  32'd1);
        chk({tag, "_rdata"}, lsu_rdata,     32'd0);
        idle_inputs;
        tick;
        chk({tag, "_idle_req"}, 32'(dm_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle_inputs;
        #12;
        chk("rst_req",   32'(dm_req),   32'd0);
        chk("rst_we",    32'(dm_we),    32'd0);
        chk("rst_be",    32'(dm_be),    32'd0);
        chk("rst_addr",  dm_addr,       32'd0);
        chk("rst_wdata", dm_wdata,      32'd0);
        chk("rst_done",  32'(lsu_done), 32'd0);
        chk("rst_err",   32'(lsu_err),  32'd0);
        chk("rst_rdata", lsu_rdata,     32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        rst = 1'b1;
        tick;

        // Aligned and sub-word stores
        run_store("sw",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        run_store("sb",  3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
        run_store("sh",  3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF);

        // Loads with extension
        run_load("lb",  3'b000, 32'h0000_0201, 32'h0000_8000, 32'h0000_0200, 4'b0010, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_0201, 32'h0000_8000, 32'h0000_0200, 4'b0010, 32'h0000_0080);
        run_load("lhu", 3'b101, 32'h0000_0202, 32'h8001_1234, 32'h0000_0200, 4'b1100, 32'h0000_8001);
        run_load("lh",  3'b001, 32'h0000_0200, 32'h0000_F00F, 32'h0000_0200, 4'b0011, 32'hFFFF_F00F);

        // Illegal requests
        run_err("ld_op011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
        run_err("st_op100", 1'b0, 1'b1, 3'b100, 32'h0000_0000);
        run_err("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h0000_0000);
        run_err("no_rd_wr", 1'b0, 1'b0, 3'b010, 32'h0000_0000);

        // LW with grant on the 4th REQ cycle, rvalid on the 2nd WAIT cycle
        lsu_valid = 1'b1; mem_rd = 1'b1; mem_op = 3'b010; addr = 32'h0000_0500;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("slow_req",   32'(dm_req),    32'd1);
            chk("slow_stall", 32'(lsu_stall), 32'd1);
            chk("slow_done",  32'(lsu_done),  32'd0);
        end
        dm_gnt = 1'b1;
        tick;
        dm_gnt = 1'b0;
        chk("slow_w1_req",   32'(dm_req),    32'd0);
        chk("slow_w1_stall", 32'(lsu_stall), 32'd1);
        chk("slow_w1_done",  32'(lsu_done),  32'd0);
        tick;
        dm_rvalid = 1'b1; dm_rdata = 32'h1357_9BDF;
        chk("slow_w2_stall", 32'(lsu_stall), 32'd1);
        chk("slow_w2_done",  32'(lsu_done),  32'd0);
        tick;
        chk("slow_done1",  32'(lsu_done),  32'd1);
        chk("slow_rdata",  lsu_rdata,      32'h1357_9BDF);
        chk("slow_err",    32'(lsu_err),   32'd0);
        chk("slow_stall0", 32'(lsu_stall), 32'd0);
        idle_inputs;
        tick;
        chk("slow_done_once", 32'(lsu_done), 32'd0);

        // Timeout: no grant ever arrives
        lsu_valid = 1'b1; mem_rd = 1'b1; mem_op = 3'b010; addr = 32'h0000_0600;
        req_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (dm_req) req_cnt++;
            chk("to_no_done", 32'(lsu_done), 32'd0);
        end
        tick;
        chk("to_req_cycles", 32'(req_cnt),  32'd16);
        chk("to_req_drop",   32'(dm_req),   32'd0);
        chk("to_done",       32'(lsu_done), 32'd1);
        chk("to_err",        32'(lsu_err),  32'd1);
        chk("to_rdata",      lsu_rdata,     32'd0);
        idle_inputs;
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hAAAA_AAAA;
        tick;
        chk("late_gnt_req",  32'(dm_req),   32'd0);
        chk("late_gnt_done", 32'(lsu_done), 32'd0);
        tick;
        chk("late_gnt_req2",  32'(dm_req),   32'd0);
        chk("late_gnt_done2", 32'(lsu_done), 32'd0);
        idle_inputs;
        tick;
        run_load("post_to", 3'b010, 32'h0000_0604, 32'h0BAD_F00D, 32'h0000_0604, 4'b1111, 32'h0BAD_F00D);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        run_err("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
`else
        run_load("lw_mis", 3'b010, 32'h0000_0102, 32'hCAFE_F00D, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D);
`endif

        // Reset while in REQ drops dm_req at once
        lsu_valid = 1'b1; mem_rd = 1'b1; mem_op = 3'b010; addr = 32'h0000_0700;
        tick;
        chk("rreq_req_before", 32'(dm_req), 32'd1);
        #2;
        rst = 1'b0;
        idle_inputs;
        #1;
        chk("rreq_req_after", 32'(dm_req), 32'd0);
        tick;
        rst = 1'b1;
        tick;

        // Reset while in WAIT; stale rvalid afterwards must not complete anything
        lsu_valid = 1'b1; mem_rd = 1'b1; mem_op = 3'b010; addr = 32'h0000_0800; dm_gnt = 1'b1;
        tick;
        tick;
        dm_gnt = 1'b0;
        chk("rwait_in_wait", 32'(dm_req), 32'd0);
        #2;
        rst = 1'b0;
        idle_inputs;
        dm_rvalid = 1'b1; dm_rdata = 32'h5555_5555;
        #1;
        chk("rwait_done",  32'(lsu_done),  32'd0);
        chk("rwait_stall", 32'(lsu_stall), 32'd0);
        tick;
        rst = 1'b1;
        tick;
        chk("rwait_stale_done1", 32'(lsu_done), 32'd0);
        chk("rwait_stale_req",   32'(dm_req),   32'd0);
        tick;
        chk("rwait_stale_done2", 32'(lsu_done), 32'd0);
        chk("rwait_stale_rdata", lsu_rdata,     32'd0);
        idle_inputs;
        tick;
        run_store("post_rst", 3'b000, 32'h0000_0901, 32'h0000_003C, 32'h0000_0900, 4'b0010, 32'h3C3C_3C3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
